// File: rtl/paddle_ctrl_pkg.sv
// Shared Pong types: paddle movement states, direction codes, screen geometry.
package pong_pkg;

    localparam int SCREEN_H = 480;
    localparam int PADDLE_H = 80;

    typedef enum logic [1:0] {
        IDLE,
        SLOW,
        FAST
    } paddle_state_t;

    typedef enum logic [1:0] {
        NONE,
        UP,
        DOWN
    } dir_t;

    function automatic int step_px(paddle_state_t s, int slow, int fast);
        return (s == FAST) ? fast : slow;
    endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Paddle controller bus: frame tick, buttons and freeze in; position and status out.
interface paddle_ctrl_if #(
    parameter int W = 10
);
    logic         tick;
    logic         up_n;
    logic         down_n;
    logic         freeze;
    logic [W-1:0] paddle_y;
    logic         up_press;
    logic         down_press;
    logic         moving;
    logic         fast;

    modport master (
        output tick, up_n, down_n, freeze,
        input  paddle_y, up_press, down_press, moving, fast
    );

    modport slave (
        input  tick, up_n, down_n, freeze,
        output paddle_y, up_press, down_press, moving, fast
    );
endinterface

// File: rtl/paddle_ctrl_btn_edge.sv
// Registered press-edge detector for an active-low button level.
module btn_edge (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic btn_n,
    output logic press
);
    logic prev_q;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b1;
            press  <= 1'b0;
        end else begin
            prev_q <= btn_n;
            press  <= prev_q & ~btn_n;
        end
    end
endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller with frame-locked movement.
// Define PADDLE_ACCEL_EN to enable hold-to-accelerate (FAST state).
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int W          = 10,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 400,
    parameter int Y_INIT     = 200,
    parameter int STEP_SLOW  = 2,
    parameter int STEP_FAST  = 6,
    parameter int HOLD_TICKS = 30
) (
    input logic          CLOCK_50,
    input logic          reset_n,
    paddle_ctrl_if.slave bus
);
    paddle_state_t state_q, state_d;
    dir_t          dir_q, dir_d, dir_in;
    logic [W-1:0]  y_q, y_d;
    logic [W:0]    step, y_sub, y_add;
    logic          up_btn, dn_btn;

`ifdef PADDLE_ACCEL_EN
    localparam int CW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    btn_edge u_up_edge (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .btn_n    (bus.up_n),
        .press    (bus.up_press)
    );

    btn_edge u_dn_edge (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .btn_n    (bus.down_n),
        .press    (bus.down_press)
    );

    assign up_btn = ~bus.up_n;
    assign dn_btn = ~bus.down_n;

    always_comb begin
        dir_in = NONE;
        unique case (1'b1)
            (up_btn & ~dn_btn): dir_in = UP;
            (dn_btn & ~up_btn): dir_in = DOWN;
            default:            dir_in = NONE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
`ifdef PADDLE_ACCEL_EN
        cnt_d   = cnt_q;
`endif
        if (bus.freeze || dir_in == NONE) begin
            state_d = IDLE;
`ifdef PADDLE_ACCEL_EN
            cnt_d   = '0;
`endif
        end else if (state_q == IDLE || dir_in != dir_q) begin
            state_d = SLOW;
            dir_d   = dir_in;
`ifdef PADDLE_ACCEL_EN
            cnt_d   = '0;
`endif
        end
`ifdef PADDLE_ACCEL_EN
        else if (state_q == SLOW && bus.tick) begin
            if (cnt_q == CW'(HOLD_TICKS - 1)) begin
                state_d = FAST;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + CW'(1);
            end
        end
`endif
    end

    // Move on the registered state; the new position shows next cycle.
    assign step  = (W+1)'(step_px(state_q, STEP_SLOW, STEP_FAST));
    assign y_sub = {1'b0, y_q} - step;
    assign y_add = {1'b0, y_q} + step;

    always_comb begin
        y_d = y_q;
        if (bus.tick && !bus.freeze && state_q != IDLE) begin
            unique case (dir_q)
                UP: begin
                    if ($signed(y_sub) < $signed((W+1)'(Y_MIN)))
                        y_d = W'(Y_MIN);
                    else
                        y_d = y_sub[W-1:0];
                end
                DOWN: begin
                    if (y_add > (W+1)'(Y_MAX))
                        y_d = W'(Y_MAX);
                    else
                        y_d = y_add[W-1:0];
                end
                default: y_d = y_q;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dir_q   <= NONE;
            y_q     <= W'(Y_INIT);
`ifdef PADDLE_ACCEL_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            y_q     <= y_d;
`ifdef PADDLE_ACCEL_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.paddle_y = y_q;
    assign bus.moving   = (state_q != IDLE);
`ifdef PADDLE_ACCEL_EN
    assign bus.fast     = (state_q == FAST);
`else
    assign bus.fast     = 1'b0;
`endif

endmodule

// File: tb/tb_paddle_ctrl.sv
// Randomized + directed bench for paddle_ctrl against a tick-level reference model.
module tb_paddle_ctrl;

    localparam int W          = 10;
    localparam int Y_MIN      = 0;
    localparam int Y_MAX      = 400;
    localparam int Y_INIT     = 200;
    localparam int STEP_SLOW  = 2;
    localparam int STEP_FAST  = 6;
    localparam int HOLD_TICKS = 30;
    localparam int TP         = 3;

    logic CLOCK_50 = 1'b0;
    logic reset_n  = 1'b0;

    paddle_ctrl_if #(.W(W)) bus ();

    paddle_ctrl #(
        .W          (W),
        .Y_MIN      (Y_MIN),
        .Y_MAX      (Y_MAX),
        .Y_INIT     (Y_INIT),
        .STEP_SLOW  (STEP_SLOW),
        .STEP_FAST  (STEP_FAST),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0 idle, 1 slow, 2 fast; dir 1 up, 2 down.
    int m_y, m_mode, m_dir, m_ticks;
    bit m_pu, m_pd, e_up, e_dn;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_y     = Y_INIT;
        m_mode  = 0;
        m_dir   = 0;
        m_ticks = 0;
        m_pu    = 1'b0;
        m_pd    = 1'b0;
        e_up    = 1'b0;
        e_dn    = 1'b0;
    endtask

    task automatic model_step(bit u, bit d, bit t, bit f);
        int step, nd;
        e_up = u && !m_pu;
        e_dn = d && !m_pd;
        m_pu = u;
        m_pd = d;
        if (t && !f && m_mode != 0) begin
            step = (m_mode == 2) ? STEP_FAST : STEP_SLOW;
            if (m_dir == 1)
                m_y = (m_y - step < Y_MIN) ? Y_MIN : m_y - step;
            else
                m_y = (m_y + step > Y_MAX) ? Y_MAX : m_y + step;
        end
        nd = (u && !d) ? 1 : (d && !u) ? 2 : 0;
        if (f || nd == 0) begin
            m_mode  = 0;
            m_ticks = 0;
        end else if (m_mode == 0 || nd != m_dir) begin
            m_mode  = 1;
            m_dir   = nd;
            m_ticks = 0;
        end else if (m_mode == 1 && t) begin
            m_ticks++;
`ifdef PADDLE_ACCEL_EN
            if (m_ticks == HOLD_TICKS) begin
                m_mode  = 2;
                m_ticks = 0;
            end
`endif
        end
    endtask

    task automatic check_all();
        chk("paddle_y", 32'(bus.paddle_y), 32'(m_y));
        chk("up_press", 32'(bus.up_press), 32'(e_up));
        chk("down_press", 32'(bus.down_press), 32'(e_dn));
        chk("moving", 32'(bus.moving), 32'(m_mode != 0));
        chk("fast", 32'(bus.fast), 32'(m_mode == 2));
    endtask

    task automatic cyc(bit u, bit d, bit t, bit f);
        @(negedge CLOCK_50);
        bus.up_n   = ~u;
        bus.down_n = ~d;
        bus.tick   = t;
        bus.freeze = f;
        @(posedge CLOCK_50);
        model_step(u, d, t, f);
        #1;
        check_all();
    endtask

    task automatic hold(bit u, bit d, bit f, int nticks);
        for (int k = 0; k < nticks; k++)
            for (int c = 0; c < TP; c++)
                cyc(u, d, (c == TP - 1), f);
    endtask

    task automatic release_btns(int n);
        for (int k = 0; k < n; k++)
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.up_n   = 1'b1;
        bus.down_n = 1'b1;
        bus.tick   = 1'b0;
        bus.freeze = 1'b0;
        model_reset();
        #35;
        chk("rst_y", 32'(bus.paddle_y), 32'(Y_INIT));
        chk("rst_moving", 32'(bus.moving), 0);
        chk("rst_fast", 32'(bus.fast), 0);
        chk("rst_up_press", 32'(bus.up_press), 0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;

        hold(1'b1, 1'b0, 1'b0, 3);
        chk("up3_y", 32'(bus.paddle_y), 194);
        release_btns(2);

        // Asynchronous reset in the middle of a hold.
        hold(1'b0, 1'b1, 1'b0, 2);
        @(posedge CLOCK_50);
        #4;
        reset_n = 1'b0;
        #1;
        chk("midrst_y", 32'(bus.paddle_y), 32'(Y_INIT));
        chk("midrst_moving", 32'(bus.moving), 0);
        model_reset();
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        release_btns(1);

        hold(1'b0, 1'b1, 1'b0, 35);
`ifdef PADDLE_ACCEL_EN
        chk("down35_y", 32'(bus.paddle_y), 290);
        chk("down35_fast", 32'(bus.fast), 1);
`else
        chk("down35_y", 32'(bus.paddle_y), 270);
        chk("down35_fast", 32'(bus.fast), 0);
`endif
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("both_idle", 32'(bus.moving), 0);
        hold(1'b1, 1'b1, 1'b0, 3);
        release_btns(2);

        hold(1'b1, 1'b0, 1'b1, 4);
        chk("freeze_moving", 32'(bus.moving), 0);
        release_btns(2);

        hold(1'b1, 1'b0, 1'b0, 150);
        chk("clamp_top", 32'(bus.paddle_y), 32'(Y_MIN));
        hold(1'b0, 1'b1, 1'b0, 250);
        chk("clamp_bot", 32'(bus.paddle_y), 32'(Y_MAX));
        hold(1'b1, 1'b0, 1'b0, 2);
        chk("rev_up", 32'(bus.paddle_y), 396);
        hold(1'b0, 1'b1, 1'b0, 1);
        chk("rev_down", 32'(bus.paddle_y), 398);

        for (int s = 0; s < 60; s++) begin
            int pat, len;
            bit f;
            pat = $urandom_range(0, 4);
            f   = ($urandom_range(0, 7) == 0);
            len = $urandom_range(1, 60);
            for (int c = 0; c < len; c++)
                cyc((pat == 1 || pat == 3 || pat == 4), (pat == 2 || pat == 3),
                    ($urandom_range(0, 2) == 0), f);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
